// File: rtl/accum_add.sv
// Two-stage read-add-writeback accumulator bank with forwarding and registered readout.
// Optional saturation and overflow flag: define ACCUM_SAT_EN (default build wraps).
module accum_add #(
    parameter int DATA_WIDTH     = 16,
    parameter int ACT_ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         comp_en_add,
    input  logic [ACT_ADDR_WIDTH-1:0]    out_act_addr_add,
    input  logic signed [DATA_WIDTH-1:0] mult_result_add,
    input  logic                         clear_en,
    input  logic                         rd_en,
    input  logic [ACT_ADDR_WIDTH-1:0]    rd_addr,
    output logic                         rd_valid,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         ovf_flag
);

    localparam int DEPTH = 2 ** ACT_ADDR_WIDTH;

    logic signed [DATA_WIDTH-1:0] r_acc [DEPTH];

    logic                         r_wb_valid;
    logic [ACT_ADDR_WIDTH-1:0]    r_wb_addr;
    logic signed [DATA_WIDTH-1:0] r_wb_sum;

    logic                         r_rd_valid;
    logic signed [DATA_WIDTH-1:0] r_rd_data;

    logic signed [DATA_WIDTH-1:0] w_operand;
    logic signed [DATA_WIDTH-1:0] w_sum;
    logic signed [DATA_WIDTH-1:0] w_rd_value;

    // A request coinciding with clear starts from zero; otherwise the in-flight
    // writeback is newer than the array for a matching address.
    always_comb begin
        w_operand = r_acc[out_act_addr_add];
        if (clear_en) begin
            w_operand = '0;
        end else if (r_wb_valid && (r_wb_addr == out_act_addr_add)) begin
            w_operand = r_wb_sum;
        end
    end

`ifdef ACCUM_SAT_EN
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH:0] w_sum_ext;
    logic                       w_overflow;
    logic                       r_ovf;

    // One guard bit: overflow when the two top bits of the extended sum disagree.
    always_comb begin
        w_sum_ext  = {w_operand[DATA_WIDTH-1], w_operand}
                   + {mult_result_add[DATA_WIDTH-1], mult_result_add};
        w_overflow = w_sum_ext[DATA_WIDTH] ^ w_sum_ext[DATA_WIDTH-1];
        w_sum      = w_sum_ext[DATA_WIDTH-1:0];
        if (w_overflow) begin
            w_sum = w_sum_ext[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (clear_en) begin
            r_ovf <= 1'b0;
        end else if (comp_en_add && w_overflow) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_flag = r_ovf;
`else
    always_comb begin
        w_sum = w_operand + mult_result_add;
    end

    assign ovf_flag = 1'b0;
`endif

    // Writeback stage; a clear on the same edge leaves only the new request pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_sum   <= '0;
        end else begin
            r_wb_valid <= comp_en_add;
            if (comp_en_add) begin
                r_wb_addr <= out_act_addr_add;
                r_wb_sum  <= w_sum;
            end
        end
    end

    // Clear takes priority over the commit, which drops the pending writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (clear_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_wb_valid) begin
            r_acc[r_wb_addr] <= r_wb_sum;
        end
    end

    // Readout reflects everything accepted before the read cycle; a request
    // accepted in the same cycle becomes visible to the next read.
    always_comb begin
        w_rd_value = r_acc[rd_addr];
        if (r_wb_valid && (r_wb_addr == rd_addr)) begin
            w_rd_value = r_wb_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= clear_en ? '0 : w_rd_value;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_accum_add.sv
// Scoreboard bench for accum_add: reads push expected data, a negedge monitor pops and compares.
module tb_accum_add;

    localparam int DW = 16;
    localparam int AW = 4;

`ifdef ACCUM_SAT_EN
    localparam int EXP_POS = 32767;
    localparam int EXP_NEG = -32768;
    localparam logic EXP_OVF = 1'b1;
`else
    localparam int EXP_POS = -32536;
    localparam int EXP_NEG = 32536;
    localparam logic EXP_OVF = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 comp_en_add = 1'b0;
    logic [AW-1:0]        out_act_addr_add = '0;
    logic signed [DW-1:0] mult_result_add = '0;
    logic                 clear_en = 1'b0;
    logic                 rd_en = 1'b0;
    logic [AW-1:0]        rd_addr = '0;
    logic                 rd_valid;
    logic signed [DW-1:0] rd_data;
    logic                 ovf_flag;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    string         name_q[$];
    logic          exp_valid;

    accum_add #(.DATA_WIDTH(DW), .ACT_ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .comp_en_add(comp_en_add),
        .out_act_addr_add(out_act_addr_add),
        .mult_result_add(mult_result_add),
        .clear_en(clear_en),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    // A read issued before an edge must produce rd_valid for exactly the following cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_valid <= 1'b0;
        else     exp_valid <= rd_en;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid !== exp_valid) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_valid_timing: got %b expected %b at %0t", rd_valid, exp_valid, $time);
            end
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rd_valid: got data %0d with no read pending", rd_data);
                end else begin
                    logic [DW-1:0] e;
                    string         nm;
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    n_vec++;
                    if (rd_data !== e) begin
                        n_err++;
                        $display("FAIL %s: rd_data got %0d expected %0d", nm, rd_data, $signed(e));
                    end else begin
                        $display("read %-20s data %0d ok", nm, rd_data);
                    end
                end
            end
        end
    end

    task automatic step(input logic ce, input int ca, input int cv, input logic clr,
                        input logic re, input int ra, input int rexp, input string nm);
        comp_en_add      = ce;
        out_act_addr_add = AW'(ca);
        mult_result_add  = DW'(cv);
        clear_en         = clr;
        rd_en            = re;
        rd_addr          = AW'(ra);
        if (re) begin
            exp_q.push_back(DW'(rexp));
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        comp_en_add = 1'b0;
        clear_en    = 1'b0;
        rd_en       = 1'b0;
    endtask

    task automatic acc(input int a, input int v);
        step(1'b1, a, v, 1'b0, 1'b0, 0, 0, "");
    endtask

    task automatic rd(input int a, input int e, input string nm);
        step(1'b0, 0, 0, 1'b0, 1'b1, a, e, nm);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, "");
    endtask

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
        end else begin
            $display("check %-20s value %0d ok", nm, $signed(act));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_valid", DW'(rd_valid), DW'(0));
        check("reset_rd_data", rd_data, DW'(0));
        check("reset_ovf", DW'(ovf_flag), DW'(0));
        rst = 1'b0;
        idle();

        // Consecutive accumulation, read served from the writeback stage then the array
        acc(2, 3);
        acc(2, 5);
        rd(2, 8, "fwd_rd_2");
        idle();
        rd(2, 8, "mem_rd_2");

        // Back-to-back same-address forwarding
        acc(7, 1);
        acc(7, 2);
        acc(7, 3);
        acc(7, 4);
        rd(7, 10, "b2b_fwd_7");
        idle();
        rd(7, 10, "b2b_mem_7");

        // Read and accumulate together: same address, then different addresses
        step(1'b1, 7, 5, 1'b0, 1'b1, 7, 10, "same_cyc_rd_7");
        rd(7, 15, "after_same_cyc_7");
        step(1'b1, 9, 20, 1'b0, 1'b1, 2, 8, "concurrent_rd_2");
        rd(9, 20, "concurrent_acc_9");

        // Signed overflow in both directions
        acc(0, 32000);
        acc(0, 1000);
        idle();
        rd(0, EXP_POS, "ovf_pos_0");
        idle();
        check("ovf_flag_pos", DW'(ovf_flag), DW'(EXP_OVF));
        acc(6, -32000);
        acc(6, -1000);
        rd(6, EXP_NEG, "ovf_neg_6");
        idle();
        check("ovf_flag_neg", DW'(ovf_flag), DW'(EXP_OVF));

        // Clear coinciding with a request to a populated entry
        acc(1, 9);
        idle();
        rd(1, 9, "pre_clear_1");
        step(1'b1, 1, 4, 1'b1, 1'b0, 0, 0, "");
        idle();
        rd(1, 4, "clear_acc_1");
        rd(0, 0, "clear_0");
        rd(2, 0, "clear_2");
        rd(6, 0, "clear_6");
        rd(7, 0, "clear_7");
        rd(9, 0, "clear_9");
        check("ovf_after_clear", DW'(ovf_flag), DW'(0));

        // Clear drops a pending writeback
        acc(4, 7);
        step(1'b0, 0, 0, 1'b1, 1'b0, 0, 0, "");
        idle();
        rd(4, 0, "clear_drops_wb_4");

        // Clear coinciding with a read returns zero
        acc(8, 3);
        idle();
        step(1'b0, 0, 0, 1'b1, 1'b1, 8, 0, "clear_rd_8");
        rd(8, 0, "after_clear_8");

        // Reset while a request is in writeback, then accept on the first edge after release
        acc(3, 11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midop_rst_rd_valid", DW'(rd_valid), DW'(0));
        check("midop_rst_rd_data", rd_data, DW'(0));
        rst = 1'b0;
        acc(5, 6);
        idle();
        rd(3, 0, "rst_discard_3");
        rd(5, 6, "post_rst_acc_5");

        repeat (3) idle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/accum_add.md
ACCUM_ADD -- requirements
Module: accum_add

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of operands, accumulators and read data.
REQ-002 SHALL have parameter ACT_ADDR_WIDTH, default 4, output activation address width; entry count = 2**ACT_ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  system reset, asynchronous, active-high.
REQ-005 SHALL have port comp_en_add  input  1  accumulate request from the multiply stage.
REQ-006 SHALL have port out_act_addr_add  input  ACT_ADDR_WIDTH  target accumulator entry.
REQ-007 SHALL have port mult_result_add  input  DATA_WIDTH  signed product to accumulate.
REQ-008 SHALL have port clear_en  input  1  clear all accumulators (one-cycle pulse).
REQ-009 SHALL have port rd_en  input  1  readout request.
REQ-010 SHALL have port rd_addr  input  ACT_ADDR_WIDTH  readout entry.
REQ-011 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  signed accumulator readout.
REQ-013 SHALL have port ovf_flag  output  1  sticky overflow indicator.

Function
REQ-014 SHALL hold an array of 2**ACT_ADDR_WIDTH signed DATA_WIDTH accumulators.
REQ-015 SHALL be two stages: add (read entry, sum) then writeback (commit); request accepted at cycle t commits at end of t+1.
REQ-016 SHALL accept one request per cycle, no backpressure, no request dropped except per REQ-020.
REQ-017 SHALL forward the writeback-stage sum as the add operand when writeback is valid and addresses match (back-to-back same-address accumulation).
REQ-018 SHALL compute sum = operand + mult_result_add in DATA_WIDTH signed two's complement; overflow per REQ-029/030.
REQ-019 SHALL on clear_en zero all entries and invalidate the pending writeback in the same edge.
REQ-020 SHALL, when comp_en_add and clear_en coincide, accept the request with operand zero (new accumulation starts from cleared state).
REQ-021 SHALL return rd_data one cycle after rd_en with rd_valid high for exactly that cycle.
REQ-022 SHALL forward a matching pending writeback sum to rd_data, so readout always shows the latest accepted value.
REQ-023 SHALL return zero on readout when clear_en coincides with rd_en.
REQ-024 SHALL allow readout and accumulation in the same cycle to any addresses, including equal ones.

Reset
REQ-025 SHALL on rst asynchronously zero all accumulators.
REQ-026 SHALL on rst clear rd_valid, rd_data, ovf_flag and writeback-stage valid/address/sum to 0.
REQ-027 SHALL discard any in-flight request when rst asserts mid-operation; no commit after release.
REQ-028 SHALL accept a new request on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL with ACCUM_SAT_EN defined clamp the sum to the most positive/negative DATA_WIDTH value on signed overflow and set ovf_flag; ovf_flag stays set until clear_en or rst.
REQ-030 SHALL with ACCUM_SAT_EN undefined wrap modulo 2**DATA_WIDTH and tie ovf_flag to 0.

Verification
REQ-031 SHALL cover: reset; accumulate 3 and 5 to addr 2 on consecutive cycles; rd_en addr 2 in the next cycle -> rd_data 8, rd_valid one cycle later.
REQ-032 SHALL cover: 4 back-to-back requests to addr 7 with 1,2,3,4 then read -> 10 (forwarding correct).
REQ-033 SHALL cover: ACCUM_SAT_EN, DATA_WIDTH 16, addr 0 holds 32000, add 1000 -> 32767, ovf_flag 1; same stimulus without macro -> -32536, ovf_flag 0.
REQ-034 SHALL cover: addr 1 holds 9, clear_en with comp_en_add addr 1 value 4 same cycle -> later read 4; all other entries 0.
REQ-035 SHALL cover: rst asserted while request to addr 3 is in writeback stage -> after release, read addr 3 returns 0.
